wptr_full_lvl: RTL and testbench

- Write-domain pointer and status block for the dual-clock FIFO inside the AXI-to-APB bridge.
- Generates the binary write address, the Gray write pointer for the read-side synchroniser, and a registered full flag.
- Also provides a free-running fill level, a programmable almost-full flag and a sticky overflow error.
- Lets upstream AXI channel logic apply backpressure early instead of stalling on wfull alone.

---
 rtl/fifo_ptr_pkg.sv | 50 +++++
 rtl/wptr_full_lvl.sv | 107 ++++++++++
 tb/tb_wptr_full_lvl.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_ptr_pkg.sv
// fifo_ptr_pkg
//   Shared pointer helpers for the dual-clock FIFO pointer blocks
//   (wptr_full_lvl on the write side, rptr_empty on the read side).
//   - PTRW(addrsize)  : pointer width, one extra wrap bit over the address.
//   - DEPTH(addrsize) : number of FIFO entries.
//   - bin2gray / gray2bin : conversions on values of up to PTR_MAX bits.
//     The active width is passed as an argument; bits at and above that
//     width are forced to zero so callers can truncate the result freely.
package fifo_ptr_pkg;

  // Widest pointer supported (ADDRSIZE up to 10 -> 11-bit pointers).
  localparam int PTR_MAX = 11;

  function automatic int PTRW(input int addrsize);
    return addrsize + 1;
  endfunction

  function automatic int DEPTH(input int addrsize);
    return 1 << addrsize;
  endfunction

  // All-ones mask covering the low w bits.
  function automatic logic [PTR_MAX-1:0] ptr_mask(input int w);
    logic [PTR_MAX:0] one_hot;
    one_hot = (PTR_MAX+1)'(1) << w;
    return PTR_MAX'(one_hot - (PTR_MAX+1)'(1));
  endfunction

  function automatic logic [PTR_MAX-1:0] bin2gray(input logic [PTR_MAX-1:0] bin,
                                                  input int w);
    logic [PTR_MAX-1:0] v;
    v = bin & ptr_mask(w);
    return (v >> 1) ^ v;
  endfunction

  // XOR prefix from the MSB down; the masked-off upper bits are zero and
  // therefore do not disturb the prefix.
  function automatic logic [PTR_MAX-1:0] gray2bin(input logic [PTR_MAX-1:0] gray,
                                                  input int w);
    logic [PTR_MAX-1:0] v;
    logic [PTR_MAX-1:0] b;
    v = gray & ptr_mask(w);
    b[PTR_MAX-1] = v[PTR_MAX-1];
    for (int i = PTR_MAX - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ v[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/wptr_full_lvl.sv
// wptr_full_lvl
//   Write-side pointer and status block of the dual-clock FIFO in the
//   AXI-to-APB bridge. Keeps the binary write pointer, publishes its Gray
//   form for the read-side synchroniser, and derives full, fill level,
//   almost-full and (optionally) a sticky overflow flag.
//
//   Optional feature macro: WPTR_FULL_OVF_EN
//     defined   : woverflow is a sticky flag set by a push attempt while
//                 full, cleared by wovf_clr (set has priority).
//     undefined : woverflow is tied to 0, wovf_clr is ignored.
//
//   Ports
//     wclk         in   write clock
//     wrst_n       in   asynchronous active-low reset
//     winc         in   push request, accepted only while wfull = 0
//     wq2_rptr     in   Gray read pointer, synchronised into wclk
//     wovf_clr     in   single-cycle clear of woverflow
//     waddr        out  binary RAM write address
//     wptr         out  registered Gray write pointer
//     wfull        out  registered full flag
//     walmost_full out  registered, level >= DEPTH - AF_MARGIN
//     wlevel       out  registered occupancy, 0..DEPTH
//     woverflow    out  sticky overflow flag
module wptr_full_lvl
  import fifo_ptr_pkg::*;
#(
  parameter int ADDRSIZE  = 4,
  parameter int AF_MARGIN = 2
) (
  input  logic                wclk,
  input  logic                wrst_n,
  input  logic                winc,
  input  logic [ADDRSIZE:0]   wq2_rptr,
  input  logic                wovf_clr,
  output logic [ADDRSIZE-1:0] waddr,
  output logic [ADDRSIZE:0]   wptr,
  output logic                wfull,
  output logic                walmost_full,
  output logic [ADDRSIZE:0]   wlevel,
  output logic                woverflow
);

  localparam int PW = PTRW(ADDRSIZE);
  localparam int D  = DEPTH(ADDRSIZE);
  localparam logic [PW-1:0] AF_LEVEL = PW'(D - AF_MARGIN);

  logic [PW-1:0] wbin;
  logic [PW-1:0] wbinnext;
  logic [PW-1:0] wgraynext;
  logic [PW-1:0] rbin;
  logic [PW-1:0] rptr_full_cmp;
  logic [PW-1:0] lvl_next;
  logic          wpush;
  logic          wfull_val;
  logic          walmost_val;

  assign wpush     = winc & ~wfull;
  assign wbinnext  = wbin + PW'(wpush);
  assign wgraynext = PW'(bin2gray(PTR_MAX'(wbinnext), PW));
  assign rbin      = PW'(gray2bin(PTR_MAX'(wq2_rptr), PW));

  // In Gray code, "exactly DEPTH ahead" means the top two bits differ and
  // the rest match.
  assign rptr_full_cmp = {~wq2_rptr[PW-1:PW-2], wq2_rptr[PW-3:0]};
  assign wfull_val     = (wgraynext == rptr_full_cmp);

  // Modulo subtraction stays correct across pointer wrap.
  assign lvl_next    = wbinnext - rbin;
  assign walmost_val = (lvl_next >= AF_LEVEL);

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin         <= '0;
      wptr         <= '0;
      wfull        <= 1'b0;
      walmost_full <= 1'b0;
      wlevel       <= '0;
    end else begin
      wbin         <= wbinnext;
      wptr         <= wgraynext;
      wfull        <= wfull_val;
      walmost_full <= walmost_val;
      wlevel       <= lvl_next;
    end
  end

  assign waddr = wbin[ADDRSIZE-1:0];

`ifdef WPTR_FULL_OVF_EN
  // Set has priority over clear so an overflow in the clearing cycle is
  // never lost.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      woverflow <= 1'b0;
    end else if (winc & wfull) begin
      woverflow <= 1'b1;
    end else if (wovf_clr) begin
      woverflow <= 1'b0;
    end
  end
`else
  logic unused_ovf_clr;
  assign unused_ovf_clr = wovf_clr;
  assign woverflow      = 1'b0;
`endif

endmodule

// File: tb/tb_wptr_full_lvl.sv
// tb_wptr_full_lvl
//   Randomised and directed checks of wptr_full_lvl (ADDRSIZE=4,
//   AF_MARGIN=2) against a count-based model: total pushes accepted and
//   total reads seen, with level = pushes - reads.
module tb_wptr_full_lvl;

  localparam int ADDRSIZE  = 4;
  localparam int AF_MARGIN = 2;
  localparam int DEPTH     = 16;

  logic       wclk;
  logic       wrst_n;
  logic       winc;
  logic [4:0] wq2_rptr;
  logic       wovf_clr;
  logic [3:0] waddr;
  logic [4:0] wptr;
  logic       wfull;
  logic       walmost_full;
  logic [4:0] wlevel;
  logic       woverflow;

  int vectors;
  int miscompares;

  // Reference model state
  int wcount;   // pushes accepted since reset
  int rcount;   // entries read since reset
  bit exp_ovf;

  wptr_full_lvl #(.ADDRSIZE(ADDRSIZE), .AF_MARGIN(AF_MARGIN)) dut (
    .wclk        (wclk),
    .wrst_n      (wrst_n),
    .winc        (winc),
    .wq2_rptr    (wq2_rptr),
    .wovf_clr    (wovf_clr),
    .waddr       (waddr),
    .wptr        (wptr),
    .wfull       (wfull),
    .walmost_full(walmost_full),
    .wlevel      (wlevel),
    .woverflow   (woverflow)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  function automatic logic [4:0] gray5(input int b);
    logic [4:0] x;
    x = 5'(b % 32);
    return x ^ (x >> 1);
  endfunction

  // Expected {waddr, wptr, wfull, walmost_full, wlevel, woverflow}
  function automatic logic [16:0] exp_vec();
    int lvl;
    lvl = wcount - rcount;
    return {4'(wcount % DEPTH), gray5(wcount), (lvl == DEPTH),
            (lvl >= DEPTH - AF_MARGIN), 5'(lvl), exp_ovf};
  endfunction

  function automatic logic [16:0] dut_vec();
    return {waddr, wptr, wfull, walmost_full, wlevel, woverflow};
  endfunction

  // One wclk cycle: drive at the falling edge, update the model at the
  // rising edge, leave outputs settled 1 time unit later.
  task automatic step(input bit inc, input int rd, input bit clr);
    bit full_prev;
    @(negedge wclk);
    full_prev = ((wcount - rcount) == DEPTH);
    winc     = inc;
    rcount   = rcount + rd;
    wq2_rptr = gray5(rcount);
    wovf_clr = clr;
    @(posedge wclk);
    if (inc && !full_prev) wcount = wcount + 1;
`ifdef WPTR_FULL_OVF_EN
    if (inc && full_prev) exp_ovf = 1'b1;
    else if (clr) exp_ovf = 1'b0;
`endif
    #1;
    $display("txn winc=%0b rd=%0d clr=%0b -> waddr=%0d wptr=%b full=%0b af=%0b lvl=%0d ovf=%0b",
             inc, rd, clr, waddr, wptr, wfull, walmost_full, wlevel, woverflow);
  endtask

  task automatic test_reset();
    wrst_n   = 1'b0;
    winc     = 1'b1;
    wovf_clr = 1'b0;
    wq2_rptr = 5'b10101;
    wcount = 0; rcount = 0; exp_ovf = 1'b0;
    repeat (3) @(posedge wclk);
    #1;
    vectors++;
    if (dut_vec() !== 17'd0) begin
      miscompares++;
      $display("FAIL reset_hold: got %h expected %h", dut_vec(), 17'd0);
    end
    @(negedge wclk);
    winc = 1'b0; wq2_rptr = 5'd0; wrst_n = 1'b1;
    step(1'b1, 0, 1'b0);
    vectors++;
    if (waddr !== 4'd1 || wptr !== 5'b00001) begin
      miscompares++;
      $display("FAIL first_push: got waddr=%0d wptr=%b expected waddr=1 wptr=00001", waddr, wptr);
    end
    vectors++;
    if (dut_vec() !== exp_vec()) begin
      miscompares++;
      $display("FAIL first_push_all: got %h expected %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 32 && wcount < 14; i++) step(1'b1, 0, 1'b0);
    vectors++;
    if (wlevel !== 5'd14 || walmost_full !== 1'b1 || wfull !== 1'b0) begin
      miscompares++;
      $display("FAIL fill_14: got lvl=%0d af=%0b full=%0b expected lvl=14 af=1 full=0",
               wlevel, walmost_full, wfull);
    end
    step(1'b1, 0, 1'b0);
    vectors++;
    if (dut_vec() !== exp_vec()) begin
      miscompares++;
      $display("FAIL fill_15: got %h expected %h", dut_vec(), exp_vec());
    end
    step(1'b1, 0, 1'b0);
    vectors++;
    if (wfull !== 1'b1 || wlevel !== 5'd16 || waddr !== 4'd0 || wptr !== 5'b11000) begin
      miscompares++;
      $display("FAIL fill_16: got full=%0b lvl=%0d waddr=%0d wptr=%b expected full=1 lvl=16 waddr=0 wptr=11000",
               wfull, wlevel, waddr, wptr);
    end
  endtask

  task automatic test_push_while_full();
    logic exp_set;
`ifdef WPTR_FULL_OVF_EN
    exp_set = 1'b1;
`else
    exp_set = 1'b0;
`endif
    repeat (3) step(1'b1, 0, 1'b0);
    vectors++;
    if (wptr !== 5'b11000 || woverflow !== exp_set) begin
      miscompares++;
      $display("FAIL ovf_set: got wptr=%b ovf=%0b expected wptr=11000 ovf=%0b", wptr, woverflow, exp_set);
    end
    step(1'b1, 0, 1'b1);
    vectors++;
    if (woverflow !== exp_set || dut_vec() !== exp_vec()) begin
      miscompares++;
      $display("FAIL ovf_set_wins: got %h expected %h", dut_vec(), exp_vec());
    end
    step(1'b0, 0, 1'b1);
    vectors++;
    if (woverflow !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_clear: got %0b expected 0", woverflow);
    end
  endtask

  task automatic test_drain();
    step(1'b0, 4, 1'b0);
    vectors++;
    if (wq2_rptr !== 5'b00110 || wlevel !== 5'd12 || wfull !== 1'b0 || walmost_full !== 1'b0) begin
      miscompares++;
      $display("FAIL drain: got rptr=%b lvl=%0d full=%0b af=%0b expected rptr=00110 lvl=12 full=0 af=0",
               wq2_rptr, wlevel, wfull, walmost_full);
    end
    step(1'b1, 1, 1'b0);
    vectors++;
    if (wlevel !== 5'd12 || dut_vec() !== exp_vec()) begin
      miscompares++;
      $display("FAIL push_and_read: got lvl=%0d vec=%h expected lvl=12 vec=%h", wlevel, dut_vec(), exp_vec());
    end
  endtask

  task automatic test_wrap();
    logic [4:0] prev;
    bit wrapped;
    wrapped = 1'b0;
    for (int i = 0; i < 40; i++) begin
      prev = wptr;
      step(1'b1, ((wcount > rcount) && ($urandom_range(0, 3) != 0)) ? 1 : 0, 1'b0);
      if (prev == 5'b10000 && wptr == 5'b00000) wrapped = 1'b1;
      vectors++;
      if (dut_vec() !== exp_vec() || $countones(wptr ^ prev) > 1) begin
        miscompares++;
        $display("FAIL wrap_step%0d: got %h (prev wptr %b) expected %h", i, dut_vec(), prev, exp_vec());
      end
    end
    vectors++;
    if (wrapped !== 1'b1) begin
      miscompares++;
      $display("FAIL wrap_seen: got %0b expected 1", wrapped);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 200; i++) begin
      step(1'($urandom_range(0, 1)),
           ((wcount > rcount) && $urandom_range(0, 1) == 1) ? 1 : 0,
           ($urandom_range(0, 7) == 0));
      vectors++;
      if (dut_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL random_step%0d: got %h expected %h", i, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    for (int i = 0; i < 64 && (wcount - rcount) != 9; i++) begin
      if ((wcount - rcount) < 9) step(1'b1, 0, 1'b0);
      else step(1'b0, 1, 1'b0);
    end
    vectors++;
    if (wlevel !== 5'd9) begin
      miscompares++;
      $display("FAIL reach_level9: got %0d expected 9", wlevel);
    end
    @(negedge wclk);
    winc = 1'b1;
    wq2_rptr = 5'b01101;
    #2 wrst_n = 1'b0;
    #1;
    wcount = 0; rcount = 0; exp_ovf = 1'b0;
    vectors++;
    if (dut_vec() !== 17'd0) begin
      miscompares++;
      $display("FAIL reset_mid_burst: got %h expected %h", dut_vec(), 17'd0);
    end
    @(negedge wclk);
    winc = 1'b0; wq2_rptr = 5'd0; wrst_n = 1'b1;
    step(1'b1, 0, 1'b0);
    vectors++;
    if (dut_vec() !== exp_vec()) begin
      miscompares++;
      $display("FAIL after_reset_push: got %h expected %h", dut_vec(), exp_vec());
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_fill();
    test_push_while_full();
    test_drain();
    test_wrap();
    test_random();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
